// File: rtl/mem_arbiter_if.sv
// Requester and mem_ctrl-side bus bundle for mem_arbiter.
// slave: the arbiter's view; master: the environment driving requests and modelling mem_ctrl.
interface mem_arbiter_if #(
  parameter int num_ports  = 4,
  parameter int addr_width = 32,
  parameter int line_width = 64
);
  logic [num_ports-1:0][addr_width-1:0] req_addr_i;
  logic [num_ports-1:0]                 req_r_valid_i;
  logic [num_ports-1:0]                 req_w_valid_i;
  logic [num_ports-1:0][line_width-1:0] req_write_i;
  logic [num_ports-1:0]                 req_ready_o;
  logic [num_ports-1:0]                 resp_valid_o;
  logic [line_width-1:0]                resp_read_o;
  logic                                 mem_enabled_i;
  logic                                 mem_data_ready_i;
  logic [addr_width-1:0]                mem_addr_o;
  logic                                 mem_r_valid_o;
  logic                                 mem_w_valid_o;
  logic [line_width-1:0]                mem_write_o;
  logic                                 mem_r_valid_i;
  logic [line_width-1:0]                mem_read_i;

  modport slave (
    input  req_addr_i, req_r_valid_i, req_w_valid_i, req_write_i,
    input  mem_enabled_i, mem_data_ready_i, mem_r_valid_i, mem_read_i,
    output req_ready_o, resp_valid_o, resp_read_o,
    output mem_addr_o, mem_r_valid_o, mem_w_valid_o, mem_write_o
  );

  modport master (
    output req_addr_i, req_r_valid_i, req_w_valid_i, req_write_i,
    output mem_enabled_i, mem_data_ready_i, mem_r_valid_i, mem_read_i,
    input  req_ready_o, resp_valid_o, resp_read_o,
    input  mem_addr_o, mem_r_valid_o, mem_w_valid_o, mem_write_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the mem_ctrl line port between num_ports requesters.
// Optional MEM_ARBITER_PRIORITY_EN: port 0 always wins; round-robin over ports 1..num_ports-1.
//
// state   | meaning
// IDLE    | waiting for a pending request while mem_ctrl is enabled and ready
// ISSUE   | one-cycle mem_r_valid_o / mem_w_valid_o pulse
// WAIT_RD | waiting for mem_r_valid_i
// WAIT_WR | waiting for mem_data_ready_i (first cycle ignored)
module mem_arbiter #(
  parameter int num_ports  = 4,
  parameter int addr_width = 32,
  parameter int line_width = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mem_arbiter_if.slave   bus
);
  localparam int gw = (num_ports > 1) ? $clog2(num_ports) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

  state_t                 state_q, state_d;
  logic [gw-1:0]          last_grant_q, last_grant_d;
  logic [gw-1:0]          grant_q, grant_d;
  logic                   is_wr_q, is_wr_d;
  logic                   wr_first_q, wr_first_d;
  logic [addr_width-1:0]  mem_addr_q, mem_addr_d;
  logic [line_width-1:0]  mem_write_q, mem_write_d;
  logic                   mem_r_valid_q, mem_r_valid_d;
  logic                   mem_w_valid_q, mem_w_valid_d;
  logic [num_ports-1:0]   resp_valid_q, resp_valid_d;
  logic [line_width-1:0]  resp_read_q, resp_read_d;

  logic [num_ports-1:0]   pending;
  logic [num_ports-1:0]   req_ready;
  logic                   found;
  logic [gw-1:0]          winner;
  int                     idx;

  always_comb begin
    pending = bus.req_r_valid_i | bus.req_w_valid_i;
    found   = 1'b0;
    winner  = '0;
    idx     = 0;
`ifdef MEM_ARBITER_PRIORITY_EN
    if (pending[0]) begin
      found = 1'b1;
    end else begin
      // ring covers ports 1..num_ports-1 only
      for (int i = 1; i < num_ports; i++) begin
        idx = int'(last_grant_q) + i;
        if (idx >= num_ports) idx = idx - (num_ports - 1);
        if (!found && pending[gw'(idx)]) begin
          found  = 1'b1;
          winner = gw'(idx);
        end
      end
    end
`else
    for (int i = 1; i <= num_ports; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= num_ports) idx = idx - num_ports;
      if (!found && pending[gw'(idx)]) begin
        found  = 1'b1;
        winner = gw'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    is_wr_d       = is_wr_q;
    wr_first_d    = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_write_d   = mem_write_q;
    mem_r_valid_d = 1'b0;
    mem_w_valid_d = 1'b0;
    resp_valid_d  = '0;
    resp_read_d   = resp_read_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (bus.mem_enabled_i && bus.mem_data_ready_i && found) begin
          req_ready[winner] = 1'b1;
          grant_d           = winner;
          is_wr_d           = bus.req_w_valid_i[winner];
          mem_addr_d        = bus.req_addr_i[winner];
          mem_write_d       = bus.req_write_i[winner];
          mem_r_valid_d     = !bus.req_w_valid_i[winner];
          mem_w_valid_d     = bus.req_w_valid_i[winner];
`ifdef MEM_ARBITER_PRIORITY_EN
          if (winner != '0) last_grant_d = winner;
`else
          last_grant_d = winner;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wr_first_d = 1'b1;
        state_d    = is_wr_q ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.mem_r_valid_i) begin
          resp_read_d           = bus.mem_read_i;
          resp_valid_d[grant_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      WAIT_WR: begin
        // mem_data_ready_i may still show the pre-issue level in the first cycle
        if (!wr_first_q && bus.mem_data_ready_i) begin
          resp_valid_d[grant_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      last_grant_q  <= gw'(num_ports - 1);
      grant_q       <= '0;
      is_wr_q       <= 1'b0;
      wr_first_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_write_q   <= '0;
      mem_r_valid_q <= 1'b0;
      mem_w_valid_q <= 1'b0;
      resp_valid_q  <= '0;
      resp_read_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      is_wr_q       <= is_wr_d;
      wr_first_q    <= wr_first_d;
      mem_addr_q    <= mem_addr_d;
      mem_write_q   <= mem_write_d;
      mem_r_valid_q <= mem_r_valid_d;
      mem_w_valid_q <= mem_w_valid_d;
      resp_valid_q  <= resp_valid_d;
      resp_read_q   <= resp_read_d;
    end
  end

  // acceptance is combinational so a held request is taken in its grant cycle
  assign bus.req_ready_o   = req_ready & {num_ports{rst_ni}};
  assign bus.resp_valid_o  = resp_valid_q;
  assign bus.resp_read_o   = resp_read_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_write_o   = mem_write_q;
  assign bus.mem_r_valid_o = mem_r_valid_q;
  assign bus.mem_w_valid_o = mem_w_valid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter; a transaction-level model predicts
// grant order, issue contents and response timing, and monitors compare at negedge.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 64;

  typedef struct { int cyc; int port; } acc_t;
  typedef struct { int cyc; bit wr; logic [AW-1:0] addr; logic [LW-1:0] data; } iss_t;
  typedef struct { int cyc; int port; bit rd; logic [LW-1:0] line; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.num_ports(N), .addr_width(AW), .line_width(LW)) bus ();
  mem_arbiter #(.num_ports(N), .addr_width(AW), .line_width(LW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  acc_t acc_q[$];
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  // reference model state
  bit            busy = 1'b0;
  bit            cur_wr;
  int            resp_at, rv_at, drhi_at, wr_issue;
  int            last = N - 1;
  logic [LW-1:0] rd_line;
  bit            hold [N];
  bit            op_w [N];
  bit            drop [N];
  logic [AW-1:0] a_p  [N];
  logic [LW-1:0] d_p  [N];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(bit [N-1:0] pend, int lg);
`ifdef MEM_ARBITER_PRIORITY_EN
    if (pend[0]) return 0;
    for (int i = 1; i < N; i++) begin
      int p;
      p = (lg - 1 + i) % (N - 1) + 1;
      if (pend[p]) return p;
    end
`else
    for (int i = 1; i <= N; i++) begin
      int p;
      p = (lg + i) % N;
      if (pend[p]) return p;
    end
`endif
    return -1;
  endfunction

  task automatic new_req(int p);
    op_w[p] = bit'($urandom_range(0, 1));
    a_p[p]  = AW'($urandom);
    d_p[p]  = {$urandom, $urandom};
    hold[p] = 1'b1;
  endtask

  task automatic drive_reqs();
    for (int p = 0; p < N; p++) begin
      bus.req_w_valid_i[p] = hold[p] && op_w[p];
      bus.req_r_valid_i[p] = hold[p] && (!op_w[p] || ($urandom_range(0, 3) == 0));
      bus.req_addr_i[p]    = a_p[p];
      bus.req_write_i[p]   = d_p[p];
    end
  endtask

  // one cycle of stimulus, called just after the rising edge of cycle cyc
  task automatic step(bit allow_new);
    bit [N-1:0] pend;
    int w, k, dl;
    for (int p = 0; p < N; p++) begin
      if (drop[p]) begin
        hold[p] = 1'b0;
        drop[p] = 1'b0;
      end else if (hold[p] && (!allow_new || (cyc > 0 && $urandom_range(0, 29) == 0))) begin
        hold[p] = 1'b0;
      end else if (!hold[p] && allow_new && $urandom_range(0, 2) == 0) begin
        new_req(p);
      end
    end
    drive_reqs();

    if (busy && cyc == resp_at) busy = 1'b0;
    bus.mem_r_valid_i = 1'b0;
    bus.mem_read_i    = {$urandom, $urandom};
    if (busy) begin
      bus.mem_enabled_i = $urandom_range(0, 1) == 1;
      if (cur_wr) begin
        if (cyc == drhi_at)                     bus.mem_data_ready_i = 1'b1;
        else if (cyc > wr_issue + 1)            bus.mem_data_ready_i = 1'b0;
        else                                    bus.mem_data_ready_i = $urandom_range(0, 1) == 1;
      end else begin
        bus.mem_data_ready_i = $urandom_range(0, 1) == 1;
        if (cyc == rv_at) begin
          bus.mem_r_valid_i = 1'b1;
          bus.mem_read_i    = rd_line;
        end
      end
    end else begin
      bus.mem_enabled_i    = (cyc == 0) || ($urandom_range(0, 4) != 0);
      bus.mem_data_ready_i = (cyc == 0) || ($urandom_range(0, 5) != 0);
      bus.mem_r_valid_i    = $urandom_range(0, 9) == 0;
    end

    for (int p = 0; p < N; p++) pend[p] = hold[p];
    if (!busy && bus.mem_enabled_i && bus.mem_data_ready_i && pend != '0) begin
      w = pick(pend, last);
      acc_q.push_back('{cyc, w});
      cur_wr = op_w[w];
      iss_q.push_back('{cyc + 1, op_w[w], a_p[w], d_p[w]});
      if (cur_wr) begin
        k        = $urandom_range(0, 4);
        wr_issue = cyc + 1;
        drhi_at  = cyc + 3 + k;
        resp_at  = drhi_at + 1;
        rsp_q.push_back('{resp_at, w, 1'b0, '0});
      end else begin
        dl      = $urandom_range(1, 6);
        rv_at   = cyc + 1 + dl;
        resp_at = rv_at + 1;
        rd_line = {$urandom, $urandom};
        rsp_q.push_back('{resp_at, w, 1'b1, rd_line});
      end
      busy    = 1'b1;
      drop[w] = 1'b1;
`ifdef MEM_ARBITER_PRIORITY_EN
      if (w != 0) last = w;
`else
      last = w;
`endif
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      acc_t ea;
      iss_t ei;
      rsp_t er;
      if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        chk("ready_missing", 64'(cyc), 64'(acc_q[0].cyc));
        void'(acc_q.pop_front());
      end
      if (bus.req_ready_o != '0) begin
        if (acc_q.size() == 0) chk("ready_unexpected", 64'(bus.req_ready_o), 64'd0);
        else begin
          ea = acc_q.pop_front();
          chk("ready_cycle", 64'(cyc), 64'(ea.cyc));
          chk("ready_port", 64'(bus.req_ready_o), 64'd1 << ea.port);
        end
      end
      if (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        chk("issue_missing", 64'(cyc), 64'(iss_q[0].cyc));
        void'(iss_q.pop_front());
      end
      if (bus.mem_r_valid_o || bus.mem_w_valid_o) begin
        chk("issue_both", 64'(bus.mem_r_valid_o & bus.mem_w_valid_o), 64'd0);
        if (iss_q.size() == 0) chk("issue_unexpected", 64'(bus.mem_w_valid_o), 64'd2);
        else begin
          ei = iss_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(ei.cyc));
          chk("issue_write_op", 64'(bus.mem_w_valid_o), 64'(ei.wr));
          chk("issue_addr", 64'(bus.mem_addr_o), 64'(ei.addr));
          if (ei.wr) chk("issue_wdata", bus.mem_write_o, ei.data);
        end
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        chk("resp_missing", 64'(cyc), 64'(rsp_q[0].cyc));
        void'(rsp_q.pop_front());
      end
      if (bus.resp_valid_o != '0) begin
        if (rsp_q.size() == 0) chk("resp_unexpected", 64'(bus.resp_valid_o), 64'd0);
        else begin
          er = rsp_q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(er.cyc));
          chk("resp_port", 64'(bus.resp_valid_o), 64'd1 << er.port);
          if (er.rd) chk("resp_line", bus.resp_read_o, er.line);
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < N; p++) begin
      new_req(p);
      drop[p] = 1'b0;
    end
    drive_reqs();
    bus.mem_enabled_i    = 1'b1;
    bus.mem_data_ready_i = 1'b1;
    bus.mem_r_valid_i    = 1'b1;
    bus.mem_read_i       = {$urandom, $urandom};

    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_resp_read", bus.resp_read_o, 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
      chk("rst_mem_write", bus.mem_write_o, 64'd0);
      chk("rst_mem_r_valid", 64'(bus.mem_r_valid_o), 64'd0);
      chk("rst_mem_w_valid", 64'(bus.mem_w_valid_o), 64'd0);
    end

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      cyc = i;
      step(i < 2940);
    end
    @(negedge clk);
    chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
    chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single `mem_ctrl` line port between `num_ports` requesters (shader cores, rasteriser, scanout). It accepts one whole-line read or write at a time, forwards it to `mem_ctrl` with a one-cycle valid pulse, waits for completion, and routes the read data or write acknowledge back to the granted requester. It sits directly above `mem_ctrl` in the memory subsystem.

## Interface
Parameters:
- `num_ports`, 4, number of requesters (≥2, power of two not required)
- `addr_width`, 32, byte address width (matches `mem_ctrl`)
- `line_width`, 64, cache line width in bits

Ports (clock, reset first):
- `clk_i`  in  1  single clock; all logic on rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `req_addr_i`  in  num_ports×addr_width  per-port byte address
- `req_r_valid_i`  in  num_ports  per-port read request, held until accepted
- `req_w_valid_i`  in  num_ports  per-port write request, held until accepted
- `req_write_i`  in  num_ports×line_width  per-port write line
- `req_ready_o`  out  num_ports  one-hot acceptance pulse
- `resp_valid_o`  out  num_ports  one-hot completion pulse (read data or write ack)
- `resp_read_o`  out  line_width  read line, valid with `resp_valid_o`
- `mem_enabled_i`  in  1  `mem_ctrl` `enabled_o`
- `mem_data_ready_i`  in  1  `mem_ctrl` `data_ready_o`
- `mem_addr_o`  out  addr_width  to `mem_ctrl` `addr_i`
- `mem_r_valid_o` / `mem_w_valid_o`  out  1  to `mem_ctrl` `r_valid_i` / `w_valid_i`
- `mem_write_o`  out  line_width  to `mem_ctrl` `write_i`
- `mem_r_valid_i`  in  1  `mem_ctrl` `r_valid_o`
- `mem_read_i`  in  line_width  `mem_ctrl` `read_o`

## Operation
- Pending[p] = `req_r_valid_i[p] | req_w_valid_i[p]`; both set means write.
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR.
- IDLE: if `mem_enabled_i & mem_data_ready_i` and any port pending, pick winner = first pending port scanning from `last_grant+1` with wrap at `num_ports-1`→0; pulse `req_ready_o[winner]`; register grant, op, address, write line; `last_grant <= winner`; go ISSUE. Otherwise stay.
- ISSUE: drive `mem_r_valid_o` or `mem_w_valid_o` high for exactly this cycle with registered `mem_addr_o`/`mem_write_o`; go WAIT_RD (read) or WAIT_WR (write).
- WAIT_RD: on `mem_r_valid_i`, register `mem_read_i` into `resp_read_o`, pulse `resp_valid_o[grant]` next cycle, go IDLE.
- WAIT_WR: first cycle ignores `mem_data_ready_i`; afterwards on `mem_data_ready_i` pulse `resp_valid_o[grant]` next cycle, go IDLE.
- `mem_r_valid_i` outside WAIT_RD ignored. `mem_enabled_i` low only blocks new grants; an in-flight op completes.
- Requester deasserting a request before acceptance is legal; it is simply not granted.

## Timing
- Reset (async assert, sync release): state IDLE, `last_grant = num_ports-1` (port 0 first), all outputs 0 including `resp_read_o`, `mem_addr_o`, `mem_write_o`.
- Accept at cycle T (`req_ready_o`), `mem_*_valid_o` at T+1, read response one cycle after `mem_r_valid_i`; write ack one cycle after the first qualifying `mem_data_ready_i`.
- Earliest next accept: cycle of the response pulse (back-to-back throughput bounded by `mem_ctrl`).
- `req_ready_o` and `mem_*_valid_o` never high two consecutive cycles; at most one bit of any one-hot output set.
- Reset asserted mid-operation abandons the op; no response is issued.

## Configuration
- `MEM_ARBITER_PRIORITY_EN` defined: port 0 (scanout) wins whenever pending; round-robin applies among ports 1..num_ports-1 only, and a port-0 grant does not move `last_grant`.
- Undefined: pure round-robin over all ports as described above.

## Test plan
- Reset: hold `rst_ni`=0 with all requests high -> every output 0; release -> port 0 accepted first.
- Single read: port 2 reads 0x100, `mem_r_valid_i` with 0xDEADBEEF_CAFEF00D 5 cycles after issue -> `resp_valid_o`=4'b0100 one cycle later with that line.
- Round-robin: all four ports hold reads -> grants in order 0,1,2,3,0; no port granted twice while another waits.
- Write: port 1 writes 0x55AA… to 0x40 -> `mem_w_valid_o` one cycle, ack `resp_valid_o`=4'b0010 after `mem_data_ready_i` returns, not in first WAIT_WR cycle.
- Stall: `mem_enabled_i`=0 with pending requests -> no `req_ready_o`; raise -> grant next cycle.
- With `MEM_ARBITER_PRIORITY_EN`: ports 0 and 3 pending continuously -> port 0 wins every grant; port 3 granted only once port 0 drops.
